seq_hit_counter: RTL
====================

# seq_hit_counter

Windowed event counter that sits directly downstream of the 0101 serial sequence detector and consumes its `z` match pulses. It counts detector hits over fixed windows of `WIN_LEN` clock cycles. At each window end it latches the saturating total into a report register, offered to the host over a valid/ready handshake. Same clock domain as the detector; `hit` is sampled only on the rising clock edge, so glitches on the detector's combinational Mealy output are harmless.

## Interface
- `CNT_W`, 8: width of accumulator and report.
- `WIN_LEN`, 256: window length in clock cycles, at least 2.
- `ALARM_TH`, 16: alarm threshold on reported count (used only with the alarm feature).
- `clk`  in  1  rising-edge clock, shared with the detector.
- `reset`  in  1  reset, synchronous, active-high.
- `hit`  in  1  detector match pulse (`z`); one count per cycle high.
- `enable`  in  1  counting enable.
- `clear`  in  1  synchronous soft clear.
- `cnt_out`  out  CNT_W  last reported window count.
- `out_valid`  out  1  report pending.
- `out_ready`  in  1  host accepts report.
- `overrun`  out  1  sticky: an unread report was overwritten.
- `live_cnt`  out  CNT_W  current accumulator value, for debug.
- `alarm`  out  1  sticky threshold alarm; constant 0 when the feature is compiled out.

## Operation
- State machine has two states.
  - IDLE: `enable`=0; accumulator and window counter held at 0.
  - RUN: counting.
- Transitions:
  - IDLE→RUN when `enable`=1.
  - RUN→IDLE when `enable`=0. The partial window is discarded; accumulator and window counter are zeroed. A pending report is kept.
- In RUN, every cycle:
  - window counter `wcnt` increments.
  - accumulator adds `hit`, saturating at 2^CNT_W−1 (no wrap).
- Window end is the RUN cycle with `wcnt`=WIN_LEN−1.
  - Report value = acc + hit (saturating). The hit in the last cycle is included.
  - acc ← 0 and `wcnt` ← 0; counting continues seamlessly into the next window.
- Handshake:
  - A report transfers on any cycle with `out_valid`=1 and `out_ready`=1.
  - `out_valid` clears the following cycle unless a new report loads in the same cycle.
  - `cnt_out` stays stable while `out_valid`=1, except when overwritten on overrun.
- Simultaneous events:
  - New report + transfer in the same cycle: new value loads, `out_valid` stays 1, no overrun.
  - New report while `out_valid`=1 and no transfer: value overwritten, `overrun` set.
- Priority: `reset` > `clear` > normal operation.
  - `clear` zeroes acc, `wcnt`, `out_valid`, `overrun` and `alarm`. State is unchanged; if in RUN, a new window starts next cycle.
- Reset mid-window: all state is discarded and no report is produced.

## Timing
- Reset values: state IDLE, `cnt_out`=0, `out_valid`=0, `overrun`=0, `live_cnt`=0, `alarm`=0.
- All outputs are registered.
- `live_cnt` reflects a hit one cycle after the hit is sampled.
- `out_valid` and `cnt_out` update the cycle after the window-end cycle.
- The first window starts on the first RUN cycle, i.e. the cycle after the `enable` rising edge is sampled. Its end is WIN_LEN cycles later.
- `overrun` and `alarm` are set one cycle after their triggering event.

## Configuration
- `SEQ_HIT_ALARM_EN` defined: `alarm` is set one cycle after a report with value ≥ `ALARM_TH` is loaded. It stays set until `clear` or `reset`.
- `SEQ_HIT_ALARM_EN` undefined: the comparator and alarm flop are absent and `alarm` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `seq_pkg`: the state encoding (IDLE=1'b0, RUN=1'b1) and default `CNT_W`/`WIN_LEN` constants, shared with the detector's state constants.
- One sub-module, `sat_accum`: a CNT_W saturating accumulator with synchronous zero. It is instanced once for the window accumulator; report saturation reuses its adder logic.

## Test plan
Bench uses `WIN_LEN`=8, `CNT_W`=4, `ALARM_TH`=3.
- Reset, `enable`=1, hit high in cycles 0, 3 and 7 of the window → `out_valid`=1 with `cnt_out`=3 one cycle after window end; `alarm`=1 in the alarm build, 0 otherwise.
- `hit` held high for 3 windows, `out_ready`=1 → each report is 8. `CNT_W`=3 variant → each report saturates at 7.
- `out_ready`=0 across two windows with 2 then 5 hits → `cnt_out`=5, `overrun`=1. A later `out_ready` pulse transfers the report; `overrun` stays 1 until `clear`.
- `out_ready`=1 asserted exactly on the cycle a new report loads → new value loads, `out_valid` stays 1, `overrun`=0.
- `enable` dropped at `wcnt`=4 after 2 hits → no report; on re-enable the next report counts only new hits.
- `clear` in the window-end cycle with 4 hits pending → no report; `out_valid`=0 and `live_cnt`=0 next cycle. `reset` mid-window → all outputs return to their reset values.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the 0101 detector and its downstream hit counter:
// state encodings and default widths.
package seq_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Detector progress through the 0101 pattern.
  typedef enum logic [1:0] {DET_S0, DET_S0X, DET_S01, DET_S010} det_state_e;

  localparam int CNT_W_DEF   = 8;
  localparam int WIN_LEN_DEF = 256;
endpackage

// File: rtl/sat_accum.sv
// W-bit saturating +0/+1 accumulator with synchronous zero. The next-value
// sum is exported so the window-end report can reuse it.
module sat_accum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         zero,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] acc,
  output logic [W-1:0] sum
);
  assign sum = (inc && acc != '1) ? acc + W'(1) : acc;

  always_ff @(posedge clk) begin
    if (reset || zero) acc <= '0;
    else if (en)       acc <= sum;
  end
endmodule

// File: rtl/seq_hit_counter.sv
// Windowed counter of detector hits with a valid/ready report register.
// Optional sticky threshold alarm enabled by defining SEQ_HIT_ALARM_EN.
module seq_hit_counter
  import seq_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int ALARM_TH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] live_cnt,
  output logic             alarm
);
  localparam int WC_W = $clog2(WIN_LEN);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_LEN - 1);

  state_e           state;
  logic [WC_W-1:0]  wcnt;
  logic [CNT_W-1:0] acc_sum;
  logic             counting, win_end, xfer;

  // A cycle in RUN with enable low is the exit cycle and does not count.
  assign counting = (state == RUN) && enable;
  assign win_end  = counting && (wcnt == WC_LAST);
  assign xfer     = out_valid && out_ready;

  sat_accum #(.W(CNT_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .zero  (clear || !counting || win_end),
    .en    (counting),
    .inc   (hit),
    .acc   (live_cnt),
    .sum   (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      cnt_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      wcnt      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= enable ? RUN : IDLE;
      wcnt  <= (counting && !win_end) ? wcnt + WC_W'(1) : '0;
      if (win_end) begin
        cnt_out   <= acc_sum;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_HIT_ALARM_EN
  logic loaded_q;

  // Compare the registered report one cycle after it loads.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      loaded_q <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      loaded_q <= win_end;
      if (loaded_q && int'(cnt_out) >= ALARM_TH) alarm <= 1'b1;
    end
  end
`else
  localparam int unused_alarm_th = ALARM_TH;
  assign alarm = 1'b0;
`endif
endmodule
